// File: rtl/rmw_sequencer.sv
// Read-modify-write bus sequencer: read, modify and write cycles at one
// address, returning N/Z/C flags for INC/DEC/ASL/LSR/ROL/ROR.
module rmw_sequencer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 16,
  parameter bit          DUMMY_WRITE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [ADDR_W-1:0] ea_i,
  input  logic              cin_i,
  input  logic              rdy_i,
  input  logic [DATA_W-1:0] idata_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] odata_o,
  output logic              rw_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              n_o,
  output logic              z_o,
  output logic              c_o
);

  localparam logic [2:0] OP_INC = 3'd0;
  localparam logic [2:0] OP_DEC = 3'd1;
  localparam logic [2:0] OP_ASL = 3'd2;
  localparam logic [2:0] OP_LSR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;
  localparam logic [2:0] OP_ROR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_MODIFY = 2'd2,
    ST_WRITE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                cin_q, cin_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic                carry_q, carry_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   odata_q, odata_d;
  logic                rw_q, rw_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                n_q, n_d;
  logic                z_q, z_d;
  logic                c_q, c_d;

  logic [DATA_W-1:0]   res_c;
  logic                carry_c;

  // ALU: result and carry-out from the latched operand, op and carry-in
  always_comb begin
    res_c   = val_q;
    carry_c = cin_q;
    case (op_q)
      OP_INC: res_c = val_q + DATA_W'(1);
      OP_DEC: res_c = val_q - DATA_W'(1);
      OP_ASL: begin
        res_c   = {val_q[DATA_W-2:0], 1'b0};
        carry_c = val_q[DATA_W-1];
      end
      OP_LSR: begin
        res_c   = {1'b0, val_q[DATA_W-1:1]};
        carry_c = val_q[0];
      end
      OP_ROL: begin
        res_c   = {val_q[DATA_W-2:0], cin_q};
        carry_c = val_q[DATA_W-1];
      end
      OP_ROR: begin
        res_c   = {cin_q, val_q[DATA_W-1:1]};
        carry_c = val_q[0];
      end
      default: ;
    endcase
  end

  // Next state and next registered bus/flag outputs
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cin_d   = cin_q;
    val_d   = val_q;
    carry_d = carry_q;
    addr_d  = addr_q;
    odata_d = odata_q;
    rw_d    = rw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;

    case (state_q)
      ST_IDLE: begin
        rw_d   = 1'b1;
        busy_d = 1'b0;
        if (start_i) begin
          op_d    = op_i;
          cin_d   = cin_i;
          addr_d  = ea_i;
          busy_d  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (rdy_i) begin
          val_d   = idata_i;
          state_d = ST_MODIFY;
          // NMOS style writes the unmodified value back during MODIFY
          if (DUMMY_WRITE) begin
            rw_d    = 1'b0;
            odata_d = idata_i;
          end else begin
            rw_d    = 1'b1;
          end
        end
      end
      ST_MODIFY: begin
        odata_d = res_c;
        carry_d = carry_c;
        rw_d    = 1'b0;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        rw_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        n_d     = odata_q[DATA_W-1];
        z_d     = (odata_q == '0);
        c_d     = carry_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; async reset forces rw high at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cin_q   <= 1'b0;
      val_q   <= '0;
      carry_q <= 1'b0;
      addr_q  <= '0;
      odata_q <= '0;
      rw_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      val_q   <= val_d;
      carry_q <= carry_d;
      addr_q  <= addr_d;
      odata_q <= odata_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  assign addr_o  = addr_q;
  assign odata_o = odata_q;
  assign rw_o    = rw_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign n_o     = n_q;
  assign z_o     = z_q;
  assign c_o     = c_q;

endmodule

// File: tb/tb_rmw_sequencer.sv
// Directed bench for rmw_sequencer: 8-bit NMOS-style and 16-bit CMOS-style instances.
module tb_rmw_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // 8-bit, dummy-write instance
  logic        start8, cin8, rdy8;
  logic [2:0]  op8;
  logic [15:0] ea8, addr8;
  logic [7:0]  idata8, odata8;
  logic        rw8, busy8, done8, n8, z8, c8;

  // 16-bit, dummy-read instance
  logic        start16, cin16, rdy16;
  logic [2:0]  op16;
  logic [15:0] ea16, addr16;
  logic [15:0] idata16, odata16;
  logic        rw16, busy16, done16, n16, z16, c16;

  rmw_sequencer #(.DATA_W(8), .ADDR_W(16), .DUMMY_WRITE(1'b1)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .op_i(op8), .ea_i(ea8),
    .cin_i(cin8), .rdy_i(rdy8), .idata_i(idata8), .addr_o(addr8),
    .odata_o(odata8), .rw_o(rw8), .busy_o(busy8), .done_o(done8),
    .n_o(n8), .z_o(z8), .c_o(c8)
  );

  rmw_sequencer #(.DATA_W(16), .ADDR_W(16), .DUMMY_WRITE(1'b0)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .op_i(op16), .ea_i(ea16),
    .cin_i(cin16), .rdy_i(rdy16), .idata_i(idata16), .addr_o(addr16),
    .odata_o(odata16), .rw_o(rw16), .busy_o(busy16), .done_o(done16),
    .n_o(n16), .z_o(z16), .c_o(c16)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] ea;
    logic        cin;
    logic [7:0]  mem;
    logic [7:0]  res;
    logic        n;
    logic        z;
    logic        c;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One 8-bit op with rdy=1; entered and left at a falling edge (done cycle on exit)
  task automatic run8(input vec_t v, output int done_cyc);
    int t0;
    int writes;
    t0 = cyc;
    writes = 0;
    start8 = 1'b1; op8 = v.op; ea8 = v.ea; cin8 = v.cin; idata8 = v.mem; rdy8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; op8 = 3'd6; ea8 = 16'hDEAD; cin8 = ~v.cin;
    chk("read_rw", 32'(rw8), 32'd1);
    chk("read_busy", 32'(busy8), 32'd1);
    chk("read_addr", 32'(addr8), 32'(v.ea));
    if (rw8 == 1'b0) writes++;
    @(negedge clk);
    idata8 = ~v.mem;
    chk("mod_rw", 32'(rw8), 32'd0);
    chk("mod_odata", 32'(odata8), 32'(v.mem));
    chk("mod_addr", 32'(addr8), 32'(v.ea));
    if (rw8 == 1'b0) writes++;
    @(negedge clk);
    chk("wr_rw", 32'(rw8), 32'd0);
    chk("wr_odata", 32'(odata8), 32'(v.res));
    chk("wr_addr", 32'(addr8), 32'(v.ea));
    chk("wr_done", 32'(done8), 32'd0);
    if (rw8 == 1'b0) writes++;
    @(negedge clk);
    chk("done", 32'(done8), 32'd1);
    chk("done_busy", 32'(busy8), 32'd0);
    chk("done_rw", 32'(rw8), 32'd1);
    chk("flag_n", 32'(n8), 32'(v.n));
    chk("flag_z", 32'(z8), 32'(v.z));
    chk("flag_c", 32'(c8), 32'(v.c));
    chk("latency", 32'(cyc - t0), 32'd4);
    chk("write_count8", 32'(writes), 32'd2);
    done_cyc = cyc;
  endtask

  // One 16-bit op; dummy-read style, so exactly one write cycle
  task automatic run16(input logic [2:0] op, input logic [15:0] mem, input logic cin,
                       input logic [15:0] res, input logic n, input logic z, input logic c);
    int t0;
    int writes;
    t0 = cyc;
    writes = 0;
    start16 = 1'b1; op16 = op; ea16 = 16'h4000; cin16 = cin; idata16 = mem; rdy16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    chk("r16_rw", 32'(rw16), 32'd1);
    chk("r16_addr", 32'(addr16), 32'h4000);
    if (rw16 == 1'b0) writes++;
    @(negedge clk);
    idata16 = 16'h1234;
    chk("m16_rw", 32'(rw16), 32'd1);
    chk("m16_busy", 32'(busy16), 32'd1);
    if (rw16 == 1'b0) writes++;
    @(negedge clk);
    chk("w16_rw", 32'(rw16), 32'd0);
    chk("w16_odata", 32'(odata16), 32'(res));
    if (rw16 == 1'b0) writes++;
    @(negedge clk);
    chk("d16_done", 32'(done16), 32'd1);
    chk("d16_n", 32'(n16), 32'(n));
    chk("d16_z", 32'(z16), 32'(z));
    chk("d16_c", 32'(c16), 32'(c));
    chk("d16_latency", 32'(cyc - t0), 32'd4);
    chk("write_count16", 32'(writes), 32'd1);
  endtask

  initial begin
    int d1;
    int d2;
    int t0;
    vec_t b1;
    vec_t b2;

    start8 = 1'b0; op8 = 3'd0; ea8 = '0; cin8 = 1'b0; rdy8 = 1'b1; idata8 = '0;
    start16 = 1'b0; op16 = 3'd0; ea16 = '0; cin16 = 1'b0; rdy16 = 1'b1; idata16 = '0;

    //               op     ea        cin   mem    res    n     z     c
    vecs[0] = '{3'd0, 16'h0080, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{3'd2, 16'h0010, 1'b0, 8'h81, 8'h02, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{3'd3, 16'h0011, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{3'd5, 16'h0012, 1'b1, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{3'd4, 16'h0013, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{3'd1, 16'hFFFF, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{3'd6, 16'h1234, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{3'd7, 16'h0001, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{3'd3, 16'h0002, 1'b1, 8'hFE, 8'h7F, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_addr", 32'(addr8), 32'd0);
    chk("rst_odata", 32'(odata8), 32'd0);
    chk("rst_rw", 32'(rw8), 32'd1);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_nzc", 32'({n8, z8, c8}), 32'd0);
    chk("rst_rw16", 32'(rw16), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single ops, each followed by an idle cycle
    for (int i = 0; i < 9; i++) begin
      run8(vecs[i], d1);
      @(negedge clk);
      chk("done_pulse", 32'(done8), 32'd0);
    end

    // Back-to-back: INC 7F -> 80, then DEC 00 -> FF started in the done cycle
    b1 = '{3'd0, 16'h0081, 1'b0, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b0};
    b2 = '{3'd1, 16'h0080, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1};
    run8(b1, d1);
    run8(b2, d2);
    chk("b2b_interval", 32'(d2 - d1), 32'd4);
    @(negedge clk);

    // rdy low for two READ cycles; stall data must not be latched
    t0 = cyc;
    start8 = 1'b1; op8 = 3'd0; ea8 = 16'h0123; cin8 = 1'b1; rdy8 = 1'b0; idata8 = 8'h55;
    @(negedge clk);
    start8 = 1'b0;
    chk("stall1_rw", 32'(rw8), 32'd1);
    chk("stall1_addr", 32'(addr8), 32'h0123);
    @(negedge clk);
    chk("stall2_rw", 32'(rw8), 32'd1);
    chk("stall2_busy", 32'(busy8), 32'd1);
    @(negedge clk);
    chk("stall3_rw", 32'(rw8), 32'd1);
    rdy8 = 1'b1; idata8 = 8'h3C;
    @(negedge clk);
    rdy8 = 1'b0; idata8 = 8'hAA;
    chk("stall_mod_rw", 32'(rw8), 32'd0);
    chk("stall_mod_odata", 32'(odata8), 32'h3C);
    @(negedge clk);
    chk("stall_wr_odata", 32'(odata8), 32'h3D);
    chk("stall_wr_rw", 32'(rw8), 32'd0);
    @(negedge clk);
    chk("stall_done", 32'(done8), 32'd1);
    chk("stall_latency", 32'(cyc - t0), 32'd6);
    chk("stall_flags", 32'({n8, z8, c8}), 32'b001);
    rdy8 = 1'b1;
    @(negedge clk);

    // Reset during MODIFY: write suppressed, flags cleared
    start8 = 1'b1; op8 = 3'd1; ea8 = 16'h0200; cin8 = 1'b1; idata8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    chk("abort_mod_rw", 32'(rw8), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_rw", 32'(rw8), 32'd1);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_flags", 32'({n8, z8, c8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_post_rw", 32'(rw8), 32'd1);
    chk("abort_post_done", 32'(done8), 32'd0);
    chk("abort_post_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    run8(vecs[3], d1);
    @(negedge clk);

    // 16-bit, dummy-read variant
    run16(3'd0, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    run16(3'd2, 16'h8001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    run16(3'd1, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
